// File: rtl/axi_pkg.sv
// Shared AXI-Stream definitions for the axi_rtl transform stage, the
// downstream packet FIFO and their benches.
//
// Contents:
//   TDATA_WIDTH  - default stream data width in bits
//   KEEP_W       - byte-enable width for the default data width
//   axis_beat_t  - one stored stream beat, packed as {tlast, tkeep, tdata}
package axi_pkg;

   localparam int TDATA_WIDTH = 32;
   localparam int KEEP_W      = TDATA_WIDTH / 8;

   typedef struct packed {
      logic              tlast;
      logic [KEEP_W-1:0] tkeep;
      logic [TDATA_WIDTH-1:0] tdata;
   } axis_beat_t;

endpackage : axi_pkg

// File: rtl/axis_fifo_mem.sv
// Beat storage for the packet FIFO: DEPTH words of BEAT_W bits with a
// registered write port and a combinational read port at the read pointer.
// It also owns the read/write pointers and the occupancy count.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset (pointers and occupancy only)
//   wr_en      - store wr_beat at the write pointer this edge
//   wr_beat    - word to store
//   rd_en      - advance the read pointer this edge
//   rd_beat    - word at the read pointer (combinational)
//   occupancy  - number of stored words, 0..DEPTH
module axis_fifo_mem #(
   parameter int BEAT_W = 37,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [BEAT_W-1:0]        wr_beat,
   input  logic                     rd_en,
   output logic [BEAT_W-1:0]        rd_beat,
   output logic [$clog2(DEPTH):0]   occupancy
);

   import axi_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE_C = {{AW{1'b0}}, 1'b1};

   logic [BEAT_W-1:0] mem_r [DEPTH];
   // Pointers carry one extra MSB so full and empty are distinguishable
   // and they wrap modulo 2*DEPTH.
   logic [AW:0]       wr_ptr_r;
   logic [AW:0]       rd_ptr_r;
   logic [AW:0]       occ_r;

   // Storage array: written on accepted beats, never reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_beat;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         occ_r    <= {(AW+1){1'b0}};
      end else begin
         if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + ONE_C;
         end
         if (rd_en) begin
            rd_ptr_r <= rd_ptr_r + ONE_C;
         end
         case ({wr_en, rd_en})
            2'b10:   occ_r <= occ_r + ONE_C;
            2'b01:   occ_r <= occ_r - ONE_C;
            default: occ_r <= occ_r;
         endcase
      end
   end

   assign rd_beat   = mem_r[rd_ptr_r[AW-1:0]];
   assign occupancy = occ_r;

endmodule : axis_fifo_mem

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO. Only complete packets (tlast
// stored) are presented to the sink. A packet longer than the buffer would
// otherwise deadlock, so when the buffer fills with no complete packet the
// block switches to cut-through until that packet's tlast leaves.
//
// Ports:
//   aclk, areset              - clock and synchronous active-high reset
//   s_axis_t{data,keep,last,valid} / s_axis_tready  - upstream stream
//   m_axis_t{data,keep,last,valid} / m_axis_tready  - downstream stream
//   occupancy                 - number of stored beats
//   pkt_count                 - number of complete packets stored
module axis_pkt_fifo #(
   parameter int TDATA_WIDTH = axi_pkg::TDATA_WIDTH,
   parameter int DEPTH       = 16
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic [TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic [TDATA_WIDTH-1:0]     m_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [$clog2(DEPTH):0]     occupancy,
   output logic [$clog2(DEPTH):0]     pkt_count
);

   import axi_pkg::*;

   localparam int KW     = TDATA_WIDTH / 8;
   localparam int BEAT_W = TDATA_WIDTH + KW + 1;
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
   localparam logic [CW-1:0] ONE_C  = {{(CW-1){1'b0}}, 1'b1};

   logic [BEAT_W-1:0] wr_beat_s;
   logic [BEAT_W-1:0] rd_beat_s;
   logic [CW-1:0]     occ_s;
   logic              wr_en_s;
   logic              rd_en_s;
   logic              wr_last_s;
   logic              rd_last_s;
   logic              valid_s;
   logic [CW-1:0]     pkt_cnt_r;
   logic [CW-1:0]     pkt_cnt_nxt_s;
   logic              fwd_r;
   logic              fwd_nxt_s;

   // Beat word layout matches axis_beat_t: {tlast, tkeep, tdata}.
   assign wr_beat_s = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

   assign s_axis_tready = !areset && (occ_s != FULL_C);

   // A null beat without tlast carries nothing, so it is accepted and dropped.
   // A null beat with tlast is kept because it closes the packet.
   assign wr_en_s   = s_axis_tvalid && s_axis_tready &&
                      (s_axis_tlast || (s_axis_tkeep != {KW{1'b0}}));
   assign wr_last_s = wr_en_s && s_axis_tlast;

   assign valid_s   = (occ_s != ZERO_C) && ((pkt_cnt_r != ZERO_C) || fwd_r);
   assign rd_en_s   = valid_s && m_axis_tready;
   assign rd_last_s = rd_en_s && rd_beat_s[BEAT_W-1];

   axis_fifo_mem #(
      .BEAT_W (BEAT_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk       (aclk),
      .rst       (areset),
      .wr_en     (wr_en_s),
      .wr_beat   (wr_beat_s),
      .rd_en     (rd_en_s),
      .rd_beat   (rd_beat_s),
      .occupancy (occ_s)
   );

   // Next-state for the complete-packet count and the cut-through flag.
   always_comb begin
      pkt_cnt_nxt_s = pkt_cnt_r;
      fwd_nxt_s     = fwd_r;
      case ({wr_last_s, rd_last_s})
         2'b10:   pkt_cnt_nxt_s = pkt_cnt_r + ONE_C;
         2'b01:   pkt_cnt_nxt_s = pkt_cnt_r - ONE_C;
         default: pkt_cnt_nxt_s = pkt_cnt_r;
      endcase
      // A full buffer holding no tlast can never drain on its own; stream it.
      if (rd_last_s) begin
         fwd_nxt_s = 1'b0;
      end else if ((occ_s == FULL_C) && (pkt_cnt_r == ZERO_C)) begin
         fwd_nxt_s = 1'b1;
      end else begin
         fwd_nxt_s = fwd_r;
      end
   end

   // Packet count and cut-through flag registers.
   always_ff @(posedge aclk) begin
      if (areset) begin
         pkt_cnt_r <= ZERO_C;
         fwd_r     <= 1'b0;
      end else begin
         pkt_cnt_r <= pkt_cnt_nxt_s;
         fwd_r     <= fwd_nxt_s;
      end
   end

   // Output payload is zeroed whenever no beat is offered. Held stable under
   // backpressure because the read pointer only moves on a transfer.
   always_comb begin
      m_axis_tvalid = valid_s;
      if (valid_s) begin
         m_axis_tlast = rd_beat_s[BEAT_W-1];
         m_axis_tkeep = rd_beat_s[BEAT_W-2 -: KW];
         m_axis_tdata = rd_beat_s[TDATA_WIDTH-1:0];
      end else begin
         m_axis_tlast = 1'b0;
         m_axis_tkeep = {KW{1'b0}};
         m_axis_tdata = {TDATA_WIDTH{1'b0}};
      end
   end

   assign occupancy = occ_s;
   assign pkt_count = pkt_cnt_r;

endmodule : axis_pkt_fifo
